// File: rtl/ahb_sram_slave.sv
// AHB slave in front of a 256x32 SRAM with programmable data-phase wait states and ERROR responses.
// Define AHB_SLV_SPLIT_EN to add SPLIT handling for unlocked reads.
module ahb_sram_slave #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SLV_ID      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ssel,
  input  logic [31:0] saddr,
  input  logic [1:0]  strans,
  input  logic        swrite,
  input  logic [2:0]  ssize,
  input  logic [2:0]  sburst,
  input  logic [3:0]  sprot,
  input  logic [3:0]  smaster,
  input  logic        smasterlock,
  input  logic [31:0] swdata,
  output logic        sready,
  output logic [1:0]  sresp,
  output logic [31:0] srdata,
  output logic [15:0] ssplit
);

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;
  localparam logic [1:0] RespSplit = 2'b11;
  localparam logic [2:0] WaitCnt   = 3'(WAIT_CYCLES);
  localparam logic [3:0] SlvId     = 4'(SLV_ID);

  typedef enum logic [2:0] {ST_OKAY, ST_WAIT, ST_ERR1, ST_ERR2, ST_SPL1, ST_SPL2} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        sready_q;
  logic [1:0]  sresp_q;
  logic        dp_active_q;
  logic        dp_write_q;
  logic        dp_hit_q;
  logic [1:0]  dp_size_q;
  logic [1:0]  dp_lane_q;
  logic [7:0]  dp_idx_q;

  logic [31:0] mem [256];

  logic        decoded;
  logic        accept;
  logic        illegal;
  logic        complete;
  logic        wr_en;
  logic [31:0] wmask;
  logic [31:0] wr_word;
  logic        split_go;
  logic        split_hit;
  logic [31:0] split_rdata;
  logic        unused_inputs;

  assign decoded  = ssel && (saddr[31:28] == SlvId);
  assign accept   = sready_q && decoded && strans[1];
  assign illegal  = (|saddr[27:10]) || (ssize > 3'b010) ||
                    (ssize == 3'b001 && saddr[0]) ||
                    (ssize == 3'b010 && saddr[1:0] != 2'b00);
  // A legal data phase finishes on the edge that ends an ST_OKAY cycle.
  assign complete = (state_q == ST_OKAY) && dp_active_q;
  assign wr_en    = complete && dp_write_q;

  always_comb begin
    wmask = '0;
    unique case (dp_size_q)
      2'b00:   wmask[{dp_lane_q, 3'b000} +: 8] = 8'hff;
      2'b01:   wmask[{dp_lane_q[1], 4'b0000} +: 16] = 16'hffff;
      default: wmask = '1;
    endcase
  end

  assign wr_word = (mem[dp_idx_q] & ~wmask) | (swdata & wmask);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[dp_idx_q] <= wr_word;
    end
  end

  assign sready = sready_q;
  assign sresp  = sresp_q;
  assign srdata = (complete && !dp_write_q) ? (dp_hit_q ? split_rdata : mem[dp_idx_q]) : '0;

`ifdef AHB_SLV_SPLIT_EN
  logic        spl_pend_q;
  logic        spl_fetched_q;
  logic [3:0]  spl_master_q;
  logic [7:0]  spl_idx_q;
  logic [2:0]  spl_cnt_q;
  logic [31:0] spl_buf_q;
  logic [15:0] ssplit_q;
  logic [31:0] fetch_word;

  assign split_go    = !swrite && !smasterlock && (WAIT_CYCLES != 0) && !spl_pend_q;
  assign split_hit   = !swrite && spl_pend_q && spl_fetched_q &&
                       (smaster == spl_master_q) && (saddr[9:2] == spl_idx_q);
  // Forward a write completing on the fetch edge so the buffer never goes stale.
  assign fetch_word  = (wr_en && dp_idx_q == spl_idx_q) ? wr_word : mem[spl_idx_q];
  assign split_rdata = spl_buf_q;
  assign ssplit      = ssplit_q;
  assign unused_inputs = ^{sburst, sprot};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spl_pend_q    <= 1'b0;
      spl_fetched_q <= 1'b0;
      spl_master_q  <= '0;
      spl_idx_q     <= '0;
      spl_cnt_q     <= '0;
      spl_buf_q     <= '0;
      ssplit_q      <= '0;
    end else begin
      ssplit_q <= '0;
      if (wr_en && spl_fetched_q && dp_idx_q == spl_idx_q) begin
        spl_buf_q <= wr_word;
      end
      if (accept && !illegal && split_hit) begin
        spl_pend_q    <= 1'b0;
        spl_fetched_q <= 1'b0;
      end else if (accept && !illegal && split_go) begin
        spl_pend_q    <= 1'b1;
        spl_fetched_q <= 1'b0;
        spl_master_q  <= smaster;
        spl_idx_q     <= saddr[9:2];
        spl_cnt_q     <= '0;
      end else if (spl_pend_q && !spl_fetched_q) begin
        if (spl_cnt_q + 3'd1 == WaitCnt) begin
          spl_fetched_q <= 1'b1;
          spl_buf_q     <= fetch_word;
          ssplit_q      <= 16'd1 << spl_master_q;
        end else begin
          spl_cnt_q <= spl_cnt_q + 3'd1;
        end
      end
    end
  end
`else
  assign split_go      = 1'b0;
  assign split_hit     = 1'b0;
  assign split_rdata   = '0;
  assign ssplit        = '0;
  assign unused_inputs = ^{sburst, sprot, smaster, smasterlock};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OKAY;
      cnt_q       <= '0;
      sready_q    <= 1'b1;
      sresp_q     <= RespOkay;
      dp_active_q <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_hit_q    <= 1'b0;
      dp_size_q   <= '0;
      dp_lane_q   <= '0;
      dp_idx_q    <= '0;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (cnt_q + 3'd1 == WaitCnt) begin
            state_q  <= ST_OKAY;
            sready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          sready_q <= 1'b1;
        end
        ST_SPL1: begin
          state_q  <= ST_SPL2;
          sready_q <= 1'b1;
        end
        // ST_OKAY, ST_ERR2, ST_SPL2: sready is high, so a new address phase may be taken.
        default: begin
          state_q     <= ST_OKAY;
          sready_q    <= 1'b1;
          sresp_q     <= RespOkay;
          dp_active_q <= 1'b0;
          dp_hit_q    <= 1'b0;
          if (accept) begin
            dp_idx_q   <= saddr[9:2];
            dp_write_q <= swrite;
            dp_size_q  <= ssize[1:0];
            dp_lane_q  <= saddr[1:0];
            cnt_q      <= '0;
            if (illegal) begin
              state_q  <= ST_ERR1;
              sready_q <= 1'b0;
              sresp_q  <= RespError;
            end else if (split_hit) begin
              dp_active_q <= 1'b1;
              dp_hit_q    <= 1'b1;
            end else if (split_go) begin
              state_q  <= ST_SPL1;
              sready_q <= 1'b0;
              sresp_q  <= RespSplit;
            end else begin
              dp_active_q <= 1'b1;
              if (WaitCnt != 3'd0) begin
                state_q  <= ST_WAIT;
                sready_q <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (WAIT_CYCLES 1, 0, 3) on one shared bus,
// selected one at a time through their ssel.
module tb_ahb_sram_slave;

  localparam logic [1:0] Okay  = 2'b00;
  localparam logic [1:0] Error = 2'b01;
  localparam logic [2:0] Byte  = 3'b000;
  localparam logic [2:0] Half  = 3'b001;
  localparam logic [2:0] Word  = 3'b010;
`ifdef AHB_SLV_SPLIT_EN
  localparam logic       DefLock = 1'b1;
`else
  localparam logic       DefLock = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ssel;
  logic [31:0] saddr;
  logic [1:0]  strans;
  logic        swrite;
  logic [2:0]  ssize;
  logic [2:0]  sburst;
  logic [3:0]  sprot;
  logic [3:0]  smaster;
  logic        smasterlock;
  logic [31:0] swdata;
  logic [1:0]  dut_sel;

  logic        rdy_w1, rdy_w0, rdy_w3;
  logic [1:0]  resp_w1, resp_w0, resp_w3;
  logic [31:0] rdata_w1, rdata_w0, rdata_w3;
  logic [15:0] split_w1, split_w0, split_w3;

  logic        m_rdy;
  logic [1:0]  m_resp;
  logic [31:0] m_rdata;
  logic [15:0] m_split;

  int checks = 0;
  int errors = 0;

  ahb_sram_slave #(.WAIT_CYCLES(1), .SLV_ID(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .ssel(ssel && dut_sel == 2'd0), .saddr(saddr), .strans(strans),
    .swrite(swrite), .ssize(ssize), .sburst(sburst), .sprot(sprot), .smaster(smaster),
    .smasterlock(smasterlock), .swdata(swdata), .sready(rdy_w1), .sresp(resp_w1),
    .srdata(rdata_w1), .ssplit(split_w1)
  );

  ahb_sram_slave #(.WAIT_CYCLES(0), .SLV_ID(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .ssel(ssel && dut_sel == 2'd1), .saddr(saddr), .strans(strans),
    .swrite(swrite), .ssize(ssize), .sburst(sburst), .sprot(sprot), .smaster(smaster),
    .smasterlock(smasterlock), .swdata(swdata), .sready(rdy_w0), .sresp(resp_w0),
    .srdata(rdata_w0), .ssplit(split_w0)
  );

  ahb_sram_slave #(.WAIT_CYCLES(3), .SLV_ID(0)) u_w3 (
    .clk(clk), .rst_n(rst_n), .ssel(ssel && dut_sel == 2'd2), .saddr(saddr), .strans(strans),
    .swrite(swrite), .ssize(ssize), .sburst(sburst), .sprot(sprot), .smaster(smaster),
    .smasterlock(smasterlock), .swdata(swdata), .sready(rdy_w3), .sresp(resp_w3),
    .srdata(rdata_w3), .ssplit(split_w3)
  );

  always_comb begin
    m_rdy   = rdy_w1;
    m_resp  = resp_w1;
    m_rdata = rdata_w1;
    m_split = split_w1;
    case (dut_sel)
      2'd1: begin m_rdy = rdy_w0; m_resp = resp_w0; m_rdata = rdata_w0; m_split = split_w0; end
      2'd2: begin m_rdy = rdy_w3; m_resp = resp_w3; m_rdata = rdata_w3; m_split = split_w3; end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_addr(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size);
    ssel   = trans[1];
    strans = trans;
    swrite = wr;
    saddr  = addr;
    ssize  = size;
  endtask

  // Single non-pipelined transfer; call just after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output int cyc, output logic rdy0,
                      output logic [1:0] resp0, output logic [31:0] rdata0,
                      output logic [1:0] resp, output logic [31:0] rdata);
    set_addr(2'b10, wr, addr, size);
    @(posedge clk); #1;
    set_addr(2'b00, 1'b0, 32'h0, Byte);
    swdata = wdata;
    cyc = 0; rdy0 = 1'b0; resp0 = '0; rdata0 = '0; resp = '0; rdata = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin rdy0 = m_rdy; resp0 = m_resp; rdata0 = m_rdata; end
      resp  = m_resp;
      rdata = m_rdata;
      if (m_rdy) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      dut_sel = 2'(k);
      #1;
      checks++;
      if ({m_rdy, m_resp, m_rdata, m_split} !== {1'b1, 2'b00, 32'h0, 16'h0}) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got rdy=%b resp=%b rdata=%h split=%h exp 1/00/0/0",
                 k, m_rdy, m_resp, m_rdata, m_split);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw;
    int cyc; logic r0; logic [1:0] p0, p; logic [31:0] d0, d;
    dut_sel = 2'd0;
    xfer(1'b1, 32'h10, Word, 32'hDEADBEEF, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 2 || r0 !== 1'b0 || p !== Okay) begin
      errors++;
      $display("FAIL word_write: got cyc=%0d rdy0=%b resp=%b exp 2/0/00", cyc, r0, p);
    end
    xfer(1'b0, 32'h10, Word, 32'h0, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 2 || p !== Okay || d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_read: got cyc=%0d resp=%b data=%h exp 2/00/deadbeef", cyc, p, d);
    end
  endtask

  task automatic test_byte_lanes;
    int cyc; logic r0; logic [1:0] p0, p; logic [31:0] d0, d;
    dut_sel = 2'd0;
    xfer(1'b1, 32'h10, Word, 32'h11223344, cyc, r0, p0, d0, p, d);
    xfer(1'b1, 32'h13, Byte, 32'hAA556677, cyc, r0, p0, d0, p, d);
    xfer(1'b0, 32'h10, Word, 32'h0, cyc, r0, p0, d0, p, d);
    checks++;
    if (d !== 32'hAA223344) begin
      errors++;
      $display("FAIL byte_lane3: got %h exp aa223344", d);
    end
    xfer(1'b1, 32'h10, Half, 32'h12347788, cyc, r0, p0, d0, p, d);
    xfer(1'b1, 32'h11, Byte, 32'hEEDD99CC, cyc, r0, p0, d0, p, d);
    xfer(1'b0, 32'h10, Word, 32'h0, cyc, r0, p0, d0, p, d);
    checks++;
    if (d !== 32'hAA229988) begin
      errors++;
      $display("FAIL half_byte_lanes: got %h exp aa229988", d);
    end
  endtask

  task automatic test_error;
    int cyc; logic r0; logic [1:0] p0, p; logic [31:0] d0, d;
    dut_sel = 2'd0;
    xfer(1'b0, 32'h400, Word, 32'h0, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 2 || r0 !== 1'b0 || p0 !== Error || p !== Error || d0 !== 32'h0 || d !== 32'h0) begin
      errors++;
      $display("FAIL err_range: got cyc=%0d rdy0=%b resp=%b/%b data=%h/%h exp 2/0/01/01/0/0",
               cyc, r0, p0, p, d0, d);
    end
    @(negedge clk);
    checks++;
    if (m_rdy !== 1'b1 || m_resp !== Okay) begin
      errors++;
      $display("FAIL err_then_idle: got rdy=%b resp=%b exp 1/00", m_rdy, m_resp);
    end
    @(posedge clk); #1;
    xfer(1'b1, 32'h12, Word, 32'hFFFFFFFF, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 2 || p0 !== Error || p !== Error) begin
      errors++;
      $display("FAIL err_word_align: got cyc=%0d resp=%b/%b exp 2/01/01", cyc, p0, p);
    end
    xfer(1'b1, 32'h11, Half, 32'hFFFFFFFF, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 2 || p !== Error) begin
      errors++;
      $display("FAIL err_half_align: got cyc=%0d resp=%b exp 2/01", cyc, p);
    end
    xfer(1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 2 || p !== Error) begin
      errors++;
      $display("FAIL err_size: got cyc=%0d resp=%b exp 2/01", cyc, p);
    end
    xfer(1'b0, 32'h10, Word, 32'h0, cyc, r0, p0, d0, p, d);
    checks++;
    if (d !== 32'hAA229988) begin
      errors++;
      $display("FAIL err_no_write: got %h exp aa229988", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [4];
    for (int k = 0; k < 4; k++) exp_d[k] = 32'hA0A0_0001 + 32'(k) * 32'h0101_0000;
    dut_sel = 2'd1;
    set_addr(2'b10, 1'b1, 32'h20, Word);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) set_addr(2'b11, 1'b1, 32'h20 + 32'(4 * k), Word);
      else set_addr(2'b00, 1'b0, 32'h0, Byte);
      swdata = exp_d[k-1];
      @(negedge clk);
      checks++;
      if (m_rdy !== 1'b1 || m_resp !== Okay) begin
        errors++;
        $display("FAIL b2b_write beat%0d: got rdy=%b resp=%b exp 1/00", k - 1, m_rdy, m_resp);
      end
      @(posedge clk); #1;
    end
    set_addr(2'b10, 1'b0, 32'h20, Word);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) set_addr(2'b11, 1'b0, 32'h20 + 32'(4 * k), Word);
      else set_addr(2'b00, 1'b0, 32'h0, Byte);
      @(negedge clk);
      checks++;
      if (m_rdy !== 1'b1 || m_rdata !== exp_d[k-1]) begin
        errors++;
        $display("FAIL b2b_read beat%0d: got rdy=%b data=%h exp 1/%h", k - 1, m_rdy, m_rdata,
                 exp_d[k-1]);
      end
      @(posedge clk); #1;
    end
    set_addr(2'b10, 1'b1, 32'h30, Word);
    @(posedge clk); #1;
    set_addr(2'b10, 1'b0, 32'h30, Word);
    swdata = 32'h5EED5EED;
    @(posedge clk); #1;
    set_addr(2'b00, 1'b0, 32'h0, Byte);
    @(negedge clk);
    checks++;
    if (m_rdy !== 1'b1 || m_rdata !== 32'h5EED5EED) begin
      errors++;
      $display("FAIL wr_then_rd: got rdy=%b data=%h exp 1/5eed5eed", m_rdy, m_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_hold;
    logic [3:0]  rdy_seq;
    logic [31:0] d;
    dut_sel = 2'd0;
    set_addr(2'b10, 1'b1, 32'h60, Word);
    @(posedge clk); #1;
    set_addr(2'b10, 1'b0, 32'h60, Word);
    swdata = 32'h600DF00D;
    @(negedge clk) rdy_seq[0] = m_rdy;
    @(posedge clk); #1;
    @(negedge clk) rdy_seq[1] = m_rdy;
    @(posedge clk); #1;
    set_addr(2'b00, 1'b0, 32'h0, Byte);
    @(negedge clk) rdy_seq[2] = m_rdy;
    @(posedge clk); #1;
    @(negedge clk) begin rdy_seq[3] = m_rdy; d = m_rdata; end
    @(posedge clk); #1;
    checks++;
    if (rdy_seq !== 4'b1010 || d !== 32'h600DF00D) begin
      errors++;
      $display("FAIL stall_hold: got rdy_seq=%b data=%h exp 1010/600df00d", rdy_seq, d);
    end
  endtask

  task automatic test_wait3_split;
    int cyc; logic r0; logic [1:0] p0, p; logic [31:0] d0, d;
    int highs; logic [15:0] sval;
    dut_sel = 2'd2;
    xfer(1'b1, 32'h40, Word, 32'hCAFEF00D, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 4 || p !== Okay) begin
      errors++;
      $display("FAIL w3_write: got cyc=%0d resp=%b exp 4/00", cyc, p);
    end
    smasterlock = 1'b1;
    xfer(1'b0, 32'h40, Word, 32'h0, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 4 || p !== Okay || d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL w3_locked_read: got cyc=%0d resp=%b data=%h exp 4/00/cafef00d", cyc, p, d);
    end
    smasterlock = 1'b0;
    smaster = 4'd2;
    xfer(1'b0, 32'h40, Word, 32'h0, cyc, r0, p0, d0, p, d);
`ifdef AHB_SLV_SPLIT_EN
    checks++;
    if (cyc !== 2 || r0 !== 1'b0 || p0 !== 2'b11 || p !== 2'b11) begin
      errors++;
      $display("FAIL split_resp: got cyc=%0d rdy0=%b resp=%b/%b exp 2/0/11/11", cyc, r0, p0, p);
    end
`else
    checks++;
    if (cyc !== 4 || p !== Okay || d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL w3_read: got cyc=%0d resp=%b data=%h exp 4/00/cafef00d", cyc, p, d);
    end
`endif
    highs = 0;
    sval  = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_split != 16'h0) begin highs++; sval = m_split; end
    end
    @(posedge clk); #1;
`ifdef AHB_SLV_SPLIT_EN
    checks++;
    if (highs !== 1 || sval !== 16'h0004) begin
      errors++;
      $display("FAIL split_release: got cycles=%0d value=%h exp 1/0004", highs, sval);
    end
    xfer(1'b0, 32'h40, Word, 32'h0, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 1 || p !== Okay || d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL split_retry: got cyc=%0d resp=%b data=%h exp 1/00/cafef00d", cyc, p, d);
    end
`else
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL ssplit_idle: got %0d cycles high exp 0", highs);
    end
`endif
    smaster = 4'd0;
    smasterlock = DefLock;
  endtask

  task automatic test_reset_mid;
    int cyc; logic r0; logic [1:0] p0, p; logic [31:0] d0, d;
    dut_sel = 2'd0;
    xfer(1'b1, 32'h50, Word, 32'h0BADC0DE, cyc, r0, p0, d0, p, d);
    set_addr(2'b10, 1'b1, 32'h50, Word);
    @(posedge clk); #1;
    set_addr(2'b00, 1'b0, 32'h0, Byte);
    swdata = 32'h12345678;
    checks++;
    if (m_rdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_state: got rdy=%b exp 0", m_rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_rdy, m_resp, m_rdata, m_split} !== {1'b1, 2'b00, 32'h0, 16'h0}) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b resp=%b rdata=%h split=%h exp 1/00/0/0",
               m_rdy, m_resp, m_rdata, m_split);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h50, Word, 32'h0, cyc, r0, p0, d0, p, d);
    checks++;
    if (cyc !== 2 || p !== Okay || d !== 32'h0BADC0DE) begin
      errors++;
      $display("FAIL reset_abort_write: got cyc=%0d resp=%b data=%h exp 2/00/0badc0de", cyc, p, d);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    dut_sel     = 2'd0;
    sburst      = 3'b001;
    sprot       = 4'b0011;
    smaster     = 4'd0;
    smasterlock = DefLock;
    swdata      = '0;
    set_addr(2'b00, 1'b0, 32'h0, Byte);
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_error();
    test_back_to_back();
    test_stall_hold();
    test_wait3_split();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
